// File: rtl/pipeline_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// pipeline_ctrl_pkg
// Shared definitions for the 5-stage core stall/flush scheduler.
//   STALL_BUS      : width of the per-stage stall vector
//                    (bit0=PC, 1=IF, 2=ID, 3=EX, 4=MEM, 5=WB)
//   STALL_*        : stall vector encodings per winning stall source
//   pctrl_state_t  : scheduler states PCTRL_RUN / PCTRL_FLUSH
//   stall_encode() : priority merge MEM > EX > ID of the stall requests
// -----------------------------------------------------------------------------
package pipeline_ctrl_pkg;

   localparam int STALL_BUS = 6;

   typedef logic [STALL_BUS-1:0] stall_t;

   // A stalled stage also holds every stage upstream of it.
   localparam stall_t STALL_NONE = 6'b000000;
   localparam stall_t STALL_ID   = 6'b000111;
   localparam stall_t STALL_EX   = 6'b001111;
   localparam stall_t STALL_MEM  = 6'b011111;

   typedef enum logic {
      PCTRL_RUN   = 1'b0,
      PCTRL_FLUSH = 1'b1
   } pctrl_state_t;

   function automatic stall_t stall_encode(input logic i_id,
                                           input logic i_ex,
                                           input logic i_mem);
      stall_t w_res;
      if (i_mem)     w_res = STALL_MEM;
      else if (i_ex) w_res = STALL_EX;
      else if (i_id) w_res = STALL_ID;
      else           w_res = STALL_NONE;
      return w_res;
   endfunction

endpackage

// File: rtl/pipeline_ctrl_if.sv
// -----------------------------------------------------------------------------
// pipeline_ctrl_if
// Bundles the stall/exception request lines from the pipeline stages and the
// stall/flush responses of the scheduler.
//   master modport : pipeline side (drives requests, receives stall/flush)
//   slave  modport : scheduler side (pipeline_ctrl)
// Signals:
//   stall_req_id/ex/mem  stage stall requests
//   exc_req, exc_pc      exception pulse and handler address
//   berr_pc              static bus-error handler address
//   stall[5:0]           per-stage hold vector
//   flush, flush_pc      one-cycle flush and redirect address
//   bus_err              one-cycle watchdog pulse
//   perf_*               perf counters (only with PIPE_CTRL_PERF_EN defined)
// -----------------------------------------------------------------------------
interface pipeline_ctrl_if #(
   parameter int CNT_WIDTH = 16
) ();
   import pipeline_ctrl_pkg::*;

   logic        stall_req_id;
   logic        stall_req_ex;
   logic        stall_req_mem;
   logic        exc_req;
   logic [31:0] exc_pc;
   logic [31:0] berr_pc;
   stall_t      stall;
   logic        flush;
   logic [31:0] flush_pc;
   logic        bus_err;
`ifdef PIPE_CTRL_PERF_EN
   logic [CNT_WIDTH-1:0] perf_id;
   logic [CNT_WIDTH-1:0] perf_ex;
   logic [CNT_WIDTH-1:0] perf_mem;
   logic [CNT_WIDTH-1:0] perf_flush;
`endif

   modport master (
      output stall_req_id, stall_req_ex, stall_req_mem,
      output exc_req, exc_pc, berr_pc,
`ifdef PIPE_CTRL_PERF_EN
      input  perf_id, perf_ex, perf_mem, perf_flush,
`endif
      input  stall, flush, flush_pc, bus_err
   );

   modport slave (
      input  stall_req_id, stall_req_ex, stall_req_mem,
      input  exc_req, exc_pc, berr_pc,
`ifdef PIPE_CTRL_PERF_EN
      output perf_id, perf_ex, perf_mem, perf_flush,
`endif
      output stall, flush, flush_pc, bus_err
   );

endinterface

// File: rtl/pipeline_ctrl_watchdog.sv
// -----------------------------------------------------------------------------
// pipe_watchdog
// Counts consecutive enabled cycles with the bus busy and raises a
// combinational expiry strobe on the cycle the count reaches TIMEOUT_CYCLES.
// The counter clears whenever the enable or busy drops, and on expiry.
// It saturates rather than wraps.
// Ports:
//   clk, rst_n  clock, asynchronous active-low reset
//   i_en        counting allowed (scheduler in RUN)
//   i_busy      MEM stage waiting on the bus
//   o_expire    timeout reached this cycle
// -----------------------------------------------------------------------------
module pipe_watchdog #(
   parameter int TIMEOUT_CYCLES = 255,
   parameter int CNT_WIDTH      = 16
) (
   input  logic clk,
   input  logic rst_n,
   input  logic i_en,
   input  logic i_busy,
   output logic o_expire
);

   // Expiry fires while the count still holds TIMEOUT_CYCLES-1, so the
   // busy cycle that would make it TIMEOUT_CYCLES is the one that expires.
   localparam logic [CNT_WIDTH-1:0] LP_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
   localparam logic [CNT_WIDTH-1:0] LP_ONE  = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

   logic [CNT_WIDTH-1:0] r_cnt;
   logic                 w_active;

   assign w_active = i_en & i_busy;
   assign o_expire = w_active & (r_cnt >= LP_LAST);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_cnt <= '0;
      end else if (!w_active || o_expire) begin
         r_cnt <= '0;
      end else if (r_cnt != {CNT_WIDTH{1'b1}}) begin
         r_cnt <= r_cnt + LP_ONE;
      end
   end

endmodule

// File: rtl/pipeline_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_ctrl
// Central stall/flush scheduler for the 5-stage core.
//   - merges ID/EX/MEM stall requests into one per-stage stall vector
//     (priority MEM > EX > ID, combinational, forced to zero in FLUSH)
//   - sequences exception flushes one cycle after the request; exceptions
//     raised while MEM waits on the bus are deferred (first one wins)
//   - watchdogs MEM bus waits and turns a hung access into a bus-error flush
// Ports:
//   clk    core clock, rising edge
//   rst_n  asynchronous active-low reset
//   bus    pipeline_ctrl_if.slave (requests in, stall/flush/bus_err out)
// Optional build macro: PIPE_CTRL_PERF_EN adds saturating perf counters
//   perf_id/perf_ex/perf_mem (winning stall cause) and perf_flush.
// -----------------------------------------------------------------------------
module pipeline_ctrl
   import pipeline_ctrl_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = 255,
   parameter int CNT_WIDTH      = 16
) (
   input  logic           clk,
   input  logic           rst_n,
   pipeline_ctrl_if.slave bus
);

   pctrl_state_t r_state;
   pctrl_state_t w_state_nxt;
   logic         r_pend;
   logic         w_pend_nxt;
   logic [31:0]  r_pend_pc;
   logic [31:0]  w_pend_pc_nxt;
   logic [31:0]  r_flush_pc;
   logic [31:0]  w_flush_pc_nxt;
   logic         r_bus_err;
   logic         w_bus_err_nxt;
   logic         w_run;
   logic         w_expire;

   assign w_run = (r_state == PCTRL_RUN);

   pipe_watchdog #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
      .CNT_WIDTH      (CNT_WIDTH)
   ) u_watchdog (
      .clk      (clk),
      .rst_n    (rst_n),
      .i_en     (w_run),
      .i_busy   (bus.stall_req_mem),
      .o_expire (w_expire)
   );

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state    <= PCTRL_RUN;
         r_pend     <= 1'b0;
         r_pend_pc  <= '0;
         r_flush_pc <= '0;
         r_bus_err  <= 1'b0;
      end else begin
         r_state    <= w_state_nxt;
         r_pend     <= w_pend_nxt;
         r_pend_pc  <= w_pend_pc_nxt;
         r_flush_pc <= w_flush_pc_nxt;
         r_bus_err  <= w_bus_err_nxt;
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      w_pend_nxt     = r_pend;
      w_pend_pc_nxt  = r_pend_pc;
      w_flush_pc_nxt = r_flush_pc;
      w_bus_err_nxt  = 1'b0;
      unique case (r_state)
         PCTRL_RUN: begin
            if (w_expire) begin
               // A hung access overrides any pending or same-cycle exception.
               w_state_nxt    = PCTRL_FLUSH;
               w_flush_pc_nxt = bus.berr_pc;
               w_bus_err_nxt  = 1'b1;
               w_pend_nxt     = 1'b0;
            end else if (!bus.stall_req_mem && (r_pend || bus.exc_req)) begin
               w_state_nxt    = PCTRL_FLUSH;
               w_flush_pc_nxt = r_pend ? r_pend_pc : bus.exc_pc;
               w_pend_nxt     = 1'b0;
            end else if (bus.stall_req_mem && bus.exc_req && !r_pend) begin
               // Let the MEM access finish; the first deferred exception wins.
               w_pend_nxt    = 1'b1;
               w_pend_pc_nxt = bus.exc_pc;
            end
         end
         PCTRL_FLUSH: begin
            w_state_nxt = PCTRL_RUN;
         end
         default: begin
            w_state_nxt = PCTRL_RUN;
         end
      endcase
   end

   assign bus.stall    = w_run ? stall_encode(bus.stall_req_id, bus.stall_req_ex,
                                              bus.stall_req_mem)
                               : STALL_NONE;
   assign bus.flush    = (r_state == PCTRL_FLUSH);
   assign bus.flush_pc = r_flush_pc;
   assign bus.bus_err  = r_bus_err;

`ifdef PIPE_CTRL_PERF_EN
   localparam logic [CNT_WIDTH-1:0] LP_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};

   logic [CNT_WIDTH-1:0] r_perf_id;
   logic [CNT_WIDTH-1:0] r_perf_ex;
   logic [CNT_WIDTH-1:0] r_perf_mem;
   logic [CNT_WIDTH-1:0] r_perf_flush;
   logic                 w_flush_entry;

   function automatic logic [CNT_WIDTH-1:0] sat_inc(input logic [CNT_WIDTH-1:0] i_v);
      return (&i_v) ? i_v : i_v + LP_ONE;
   endfunction

   assign w_flush_entry = w_run && (w_state_nxt == PCTRL_FLUSH);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_perf_id    <= '0;
         r_perf_ex    <= '0;
         r_perf_mem   <= '0;
         r_perf_flush <= '0;
      end else begin
         // Only the winning cause of a RUN-state stall is counted.
         if (w_run) begin
            if (bus.stall_req_mem)     r_perf_mem <= sat_inc(r_perf_mem);
            else if (bus.stall_req_ex) r_perf_ex  <= sat_inc(r_perf_ex);
            else if (bus.stall_req_id) r_perf_id  <= sat_inc(r_perf_id);
         end
         if (w_flush_entry) r_perf_flush <= sat_inc(r_perf_flush);
      end
   end

   assign bus.perf_id    = r_perf_id;
   assign bus.perf_ex    = r_perf_ex;
   assign bus.perf_mem   = r_perf_mem;
   assign bus.perf_flush = r_perf_flush;
`endif

endmodule

// File: doc/pipeline_ctrl.md
Name: pipeline_ctrl

Overview:
- Central stall/flush scheduler for the 5-stage core (PC, IF, ID, EX, MEM, WB).
- Merges stall requests from ID (load-use bubble from operand generation), EX (multi-cycle ALU op) and MEM (bus wait) into one per-stage stall vector.
- Sequences exception flushes, including redirecting the PC to the handler address.
- Watchdogs MEM bus waits and converts a hung access into a bus-error flush.

Parameters:
- TIMEOUT_CYCLES, 255: MEM-stall cycles tolerated before bus error; legal range 1..65535.
- CNT_WIDTH, 16: width of the watchdog counter and the perf counters.

Ports:
- clk  in  1  core clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- stall_req_id  in  1  ID needs one bubble (load-use on operand_1/operand_2 source).
- stall_req_ex  in  1  EX busy with a multi-cycle op.
- stall_req_mem  in  1  MEM waiting on the bus.
- exc_req  in  1  single-cycle exception pulse from MEM.
- exc_pc  in  32  handler address, qualified by exc_req.
- berr_pc  in  32  bus-error handler address (static).
- stall  out  6  bit0=PC, 1=IF, 2=ID, 3=EX, 4=MEM, 5=WB; 1 = hold stage.
- flush  out  1  clears the IF..MEM pipeline registers.
- flush_pc  out  32  new PC, valid while flush=1.
- bus_err  out  1  one-cycle pulse when the watchdog fires.

Behaviour:
- Reset values: stall=0, flush=0, flush_pc=0, bus_err=0, state=RUN, pending=0, watchdog=0.
- States: RUN, FLUSH.
  - RUN → FLUSH when (exc_req or pending or watchdog expiry) and stall_req_mem=0 (or when expiry occurs).
  - FLUSH → RUN unconditionally after 1 cycle.
- stall is combinational from the current requests and state. Priority MEM > EX > ID:
  - In RUN: mem → 6'b011111; else ex → 6'b001111; else id → 6'b000111; else 6'b000000.
  - In FLUSH: stall = 0 and all requests are ignored.
- Exception while stall_req_mem=1: the MEM access completes first.
  - exc_pc is latched into the pending register, pending=1, and the exception is deferred.
  - A later exc_req while pending=1 is dropped; the first one wins.
- Flush timing: registered. The request is seen in cycle N; in cycle N+1, flush=1 for exactly one cycle and flush_pc = the latched address. pending clears on entry to FLUSH.
- Watchdog:
  - Counts consecutive RUN cycles with stall_req_mem=1 and clears when it drops.
  - When the count reaches TIMEOUT_CYCLES: bus_err pulses, state goes to FLUSH with flush_pc=berr_pc (overrides any pending exception), and the counter clears.
  - The counter saturates and does not wrap.
- Simultaneous exc_req and watchdog expiry: the watchdog wins; the exception is discarded.
- Reset mid-FLUSH or mid-stall: all state returns to reset values immediately (asynchronous); no flush pulse is emitted after release.

Optional Feature:
- PIPE_CTRL_PERF_EN defined:
  - Adds outputs perf_id, perf_ex, perf_mem (each CNT_WIDTH, saturating), incremented on cycles where that source is the winning stall cause, plus perf_flush counting flushes.
  - All cleared by reset only.
- Undefined: these ports and counters are absent; all other behaviour is identical.

Decomposition:
- Shared bus/definitions header gains:
  - STALL_BUS (5:0);
  - stall encodings STALL_NONE, STALL_ID, STALL_EX, STALL_MEM;
  - state encodings PCTRL_RUN, PCTRL_FLUSH.
- One natural sub-module: pipe_watchdog (counter, saturation, expiry pulse), parameterised by TIMEOUT_CYCLES/CNT_WIDTH.

Test Plan:
- Priority: stall_req_id=1 alone → stall=6'b000111; assert id+ex+mem together → stall=6'b011111 in the same cycle.
- Plain exception: exc_req with exc_pc=0xBFC00380 in RUN, cycle N → cycle N+1 flush=1, flush_pc=0xBFC00380, stall=0; cycle N+2 flush=0.
- Deferred exception: stall_req_mem=1 for 5 cycles, exc_req at cycle 2 (0x80000180), second exc_req at cycle 3 (0x1234) → flush one cycle after mem drops, flush_pc=0x80000180.
- Watchdog: TIMEOUT_CYCLES=4, hold stall_req_mem=1 → after 4 cycles bus_err=1 for 1 cycle, flush=1 with flush_pc=berr_pc; a pending exception is discarded.
- Reset mid-flush: drop rst_n during the FLUSH cycle → flush, stall, and bus_err go to 0 asynchronously; after release, state=RUN with no spurious flush.
- With PIPE_CTRL_PERF_EN: 3 cycles ID stall + 2 cycles EX stall + 1 exception → perf_id=3, perf_ex=2, perf_mem=0, perf_flush=1.
